// File: rtl/meas_pkg.sv
// Shared measure_unit definitions: DAC frame geometry, DAC command nibble and
// the threshold-DAC arbiter state encoding.
`default_nettype none

package meas_pkg;

  localparam int         DAC_CODE_WIDTH     = 16;
  localparam int         DAC_DATA_WIDTH     = 24;
  localparam logic [3:0] DAC_CMD_WRITE      = 4'b0011;
  localparam int         DAC_TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_BUSY  = 2'd2
  } dac_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dac_spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between two threshold-DAC
// requesters; routes the master's sync line to the granted DAC.
`default_nettype none

module dac_spi_arbiter
  import meas_pkg::*;
#(
  parameter int         CODE_WIDTH     = DAC_CODE_WIDTH,
  parameter logic [3:0] CMD_NIBBLE     = DAC_CMD_WRITE,
  parameter int         SPI_DATA_WIDTH = DAC_DATA_WIDTH,
  parameter int         TIMEOUT_CYCLES = DAC_TIMEOUT_CYCLES
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [CODE_WIDTH-1:0]     req1_code_i,
  input  logic                      req1_wre_i,
  output logic                      req1_rdy_o,
  input  logic [CODE_WIDTH-1:0]     req2_code_i,
  input  logic                      req2_wre_i,
  output logic                      req2_rdy_o,
  output logic [SPI_DATA_WIDTH-1:0] spi_data_o,
  output logic                      spi_wre_o,
  input  logic                      spi_rdy_i,
  input  logic                      spi_sync_i,
  output logic                      dac1_sync_o,
  output logic                      dac2_sync_o,
  output logic                      busy_o,
  output logic                      drop_o,
  output logic                      err_o,
  input  logic                      err_clr_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  dac_arb_state_t          state, state_d;
  logic                    pend1, pend2;
  logic [CODE_WIDTH-1:0]   code1, code2;
  logic                    ptr;       // 0: ch1 has priority, 1: ch2
  logic                    sel;       // 0: ch1 granted, 1: ch2 granted
  logic [CNT_W-1:0]        cnt;
  logic                    grant, grant_ch, done, timeout, finish;
  logic                    acc1, acc2;

  assign acc1   = req1_wre_i & ~pend1;
  assign acc2   = req2_wre_i & ~pend2;
  assign finish = done | timeout;

  always_comb begin
    state_d  = state;
    grant    = 1'b0;
    grant_ch = ptr;
    done     = 1'b0;
    timeout  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if ((pend1 | pend2) && spi_rdy_i) begin
          grant    = 1'b1;
          grant_ch = (pend1 && pend2) ? ptr : pend2;
          state_d  = ARB_START;
        end
      end
      ARB_START: begin
        if (!spi_rdy_i) begin
          state_d = ARB_BUSY;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (spi_rdy_i) begin
          done    = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ARB_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pend1      <= 1'b0;
      pend2      <= 1'b0;
      code1      <= '0;
      code2      <= '0;
      ptr        <= 1'b0;
      sel        <= 1'b0;
      cnt        <= '0;
      spi_data_o <= '0;
      spi_wre_o  <= 1'b0;
      drop_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      spi_wre_o <= grant;
      // A write to a slot that is still pending or in flight is discarded.
      drop_o    <= (req1_wre_i & pend1) | (req2_wre_i & pend2);
      cnt       <= (state == ARB_START) ? cnt + 1'b1 : '0;

      if (acc1) begin
        pend1 <= 1'b1;
        code1 <= req1_code_i;
      end
      if (acc2) begin
        pend2 <= 1'b1;
        code2 <= req2_code_i;
      end
      if (finish && !sel) pend1 <= 1'b0;
      if (finish &&  sel) pend2 <= 1'b0;

      if (grant) begin
        sel        <= grant_ch;
        spi_data_o <= SPI_DATA_WIDTH'({CMD_NIBBLE, (grant_ch ? code2 : code1), 4'b0000});
      end

      if (done)         ptr <= ~sel;
      else if (timeout) ptr <= ~ptr;

      if (timeout)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
  end

  // sel only moves in IDLE, so gating on state keeps both sync pins glitch-free.
  assign dac1_sync_o = (state != ARB_IDLE && !sel) ? spi_sync_i : 1'b1;
  assign dac2_sync_o = (state != ARB_IDLE &&  sel) ? spi_sync_i : 1'b1;

  assign busy_o     = (state != ARB_IDLE);
  assign req1_rdy_o = ~pend1;
  assign req2_rdy_o = ~pend2;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_arbiter.sv
// Directed bench for dac_spi_arbiter with a small behavioural SPI-master
// model that logs each completed frame and which DAC sync pin went low.
`default_nettype none

module tb_dac_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req1_code = '0, req2_code = '0;
  logic        req1_wre = 1'b0, req2_wre = 1'b0;
  logic        req1_rdy, req2_rdy;
  logic [23:0] spi_data;
  logic        spi_wre, spi_rdy, spi_sync;
  logic        dac1_sync, dac2_sync, busy, drop, err;
  logic        err_clr = 1'b0;
  logic        model_en = 1'b1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dac_spi_arbiter dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .req1_code_i (req1_code),
    .req1_wre_i  (req1_wre),
    .req1_rdy_o  (req1_rdy),
    .req2_code_i (req2_code),
    .req2_wre_i  (req2_wre),
    .req2_rdy_o  (req2_rdy),
    .spi_data_o  (spi_data),
    .spi_wre_o   (spi_wre),
    .spi_rdy_i   (spi_rdy),
    .spi_sync_i  (spi_sync),
    .dac1_sync_o (dac1_sync),
    .dac2_sync_o (dac2_sync),
    .busy_o      (busy),
    .drop_o      (drop),
    .err_o       (err),
    .err_clr_i   (err_clr)
  );

  // SPI master model: 3 wait cycles, 24 cycles sync low, 3 tail cycles.
  logic [1:0]  m_state;
  logic [4:0]  m_cnt;
  logic        m_rdy, m_sync, seen1, seen2;
  logic [23:0] m_data;
  logic [23:0] log_data [16];
  logic        log_s1 [16];
  logic        log_s2 [16];
  int          log_n = 0;

  assign spi_rdy  = model_en ? m_rdy : 1'b1;
  assign spi_sync = m_sync;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 2'd0;
      m_cnt   <= '0;
      m_rdy   <= 1'b1;
      m_sync  <= 1'b1;
      seen1   <= 1'b0;
      seen2   <= 1'b0;
    end else begin
      if (m_state != 2'd0) begin
        if (!dac1_sync) seen1 <= 1'b1;
        if (!dac2_sync) seen2 <= 1'b1;
      end
      case (m_state)
        2'd0: if (spi_wre && model_en) begin
          m_data  <= spi_data;
          m_rdy   <= 1'b0;
          m_state <= 2'd1;
          m_cnt   <= '0;
          seen1   <= 1'b0;
          seen2   <= 1'b0;
        end
        2'd1: if (m_cnt == 5'd2) begin
          m_state <= 2'd2; m_sync <= 1'b0; m_cnt <= '0;
        end else m_cnt <= m_cnt + 5'd1;
        2'd2: if (m_cnt == 5'd23) begin
          m_state <= 2'd3; m_sync <= 1'b1; m_cnt <= '0;
        end else m_cnt <= m_cnt + 5'd1;
        default: if (m_cnt == 5'd2) begin
          m_state <= 2'd0;
          m_rdy   <= 1'b1;
          if (log_n < 16) begin
            log_data[log_n] <= m_data;
            log_s1[log_n]   <= seen1;
            log_s2[log_n]   <= seen2;
          end
          log_n <= log_n + 1;
        end else m_cnt <= m_cnt + 5'd1;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [15:0] c);
    @(negedge clk);
    req1_code = c; req1_wre = 1'b1;
    @(posedge clk); #1;
    req1_wre = 1'b0;
  endtask

  task automatic write2(input logic [15:0] c);
    @(negedge clk);
    req2_code = c; req2_wre = 1'b1;
    @(posedge clk); #1;
    req2_wre = 1'b0;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 400 && log_n < n; i++) @(posedge clk);
    #1;
    chk("frame_count", log_n, n);
  endtask

  task automatic chk_frame(input string tag, input int idx, input logic [23:0] f,
                           input logic s1, input logic s2);
    chk(tag, {6'd0, log_s1[idx], log_s2[idx], log_data[idx]}, {6'd0, s1, s2, f});
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int base;
    // Reset state
    cyc(3);
    chk("reset_flags", {24'd0, req1_rdy, req2_rdy, busy, spi_wre, drop, err, dac1_sync, dac2_sync},
        32'h0000_00C3);
    chk("reset_data", {8'd0, spi_data}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Single ch1 write
    write1(16'hA5C3);
    chk("ch1_rdy_low", {31'd0, req1_rdy}, 32'd0);
    wait_log(1);
    chk_frame("ch1_frame", 0, 24'h3A5C30, 1'b1, 1'b0);
    cyc(3);
    chk("ch1_rdy_back", {30'd0, req1_rdy, busy}, 32'b10);

    // Simultaneous writes with pointer at ch1
    pulse_reset();
    @(negedge clk);
    req1_code = 16'h1111; req2_code = 16'h2222; req1_wre = 1'b1; req2_wre = 1'b1;
    @(posedge clk); #1;
    req1_wre = 1'b0; req2_wre = 1'b0;
    chk("both_rdy_low", {30'd0, req1_rdy, req2_rdy}, 32'd0);
    wait_log(3);
    chk_frame("both_first", 1, 24'h311110, 1'b1, 1'b0);
    chk_frame("both_second", 2, 24'h322220, 1'b0, 1'b1);

    // Write during own in-flight frame is dropped
    cyc(3);
    write1(16'h1234);
    for (int i = 0; i < 20 && !(busy && !spi_rdy); i++) cyc(1);
    chk("inflight", {30'd0, busy, spi_rdy}, 32'b10);
    write1(16'h5678);
    chk("drop_pulse", {30'd0, drop, req1_rdy}, 32'b10);
    cyc(1);
    chk("drop_end", {31'd0, drop}, 32'd0);
    wait_log(4);
    chk_frame("drop_frame", 3, 24'h312340, 1'b1, 1'b0);
    cyc(60);
    chk("no_extra_frame", log_n, 4);

    // Round-robin: ch1, ch2, ch1, ch2
    base = log_n;
    write1(16'h0001);
    write2(16'h0002);
    for (int i = 0; i < 200 && !req1_rdy; i++) cyc(1);
    write1(16'h0003);
    for (int i = 0; i < 200 && !req2_rdy; i++) cyc(1);
    write2(16'h0004);
    wait_log(base + 4);
    chk_frame("rr_0", base,     24'h300010, 1'b1, 1'b0);
    chk_frame("rr_1", base + 1, 24'h300020, 1'b0, 1'b1);
    chk_frame("rr_2", base + 2, 24'h300030, 1'b1, 1'b0);
    chk_frame("rr_3", base + 3, 24'h300040, 1'b0, 1'b1);

    // Timeout with spi_rdy stuck high
    cyc(5);
    model_en = 1'b0;
    write1(16'hBEEF);
    cyc(15);
    chk("err_before_timeout", {31'd0, err}, 32'd0);
    cyc(1);
    chk("err_timeout", {28'd0, err, req1_rdy, busy, drop}, 32'b1100);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);
    model_en = 1'b1;

    // Async reset mid-frame
    cyc(3);
    base = log_n;
    write2(16'h7777);
    for (int i = 0; i < 40 && dac2_sync; i++) cyc(1);
    chk("dac2_active", {30'd0, dac1_sync, dac2_sync}, 32'b10);
    #2 rst = 1'b1;
    #1;
    chk("midreset", {27'd0, dac1_sync, dac2_sync, req1_rdy, req2_rdy, busy}, 32'b11110);
    @(negedge clk); rst = 1'b0;
    write1(16'h4242);
    wait_log(base + 1);
    chk_frame("post_reset", base, 24'h342420, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
